// File: rtl/sort_pkg.sv
// Shared constants and helpers for the sort datapath.
// Select codes for the bank write mux and the flat-bus slice helper.
package sort_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam int MAX_W     = 64;
    localparam int MAX_FLAT  = 1024;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_STREAM,
        SEL_WD,
        SEL_SWAP
    } sel_t;

    // Entry i of a flat bus with w-bit entries, zero-extended to MAX_W bits.
    function automatic logic [MAX_W-1:0] entry_of(
        input logic [MAX_FLAT-1:0] flat,
        input int                  w,
        input int                  i
    );
        logic [MAX_FLAT-1:0] s;
        logic [MAX_W-1:0]    m;
        s = flat >> (i * w);
        m = (MAX_W'(1) << w) - MAX_W'(1);
        return s[MAX_W-1:0] & m;
    endfunction

endpackage

// File: rtl/sort_bank_ctrl.sv
// Load pointer, fill status and per-cycle update decode for sort_bank.
// Emits one-hot entry write enables and a shared source select.
module sort_bank_ctrl
    import sort_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             swap_en,
    input  logic [AW-1:0]    swap_a,
    input  logic [AW-1:0]    swap_b,
    output logic             in_ready,
    output logic [DEPTH-1:0] wen,
    output sel_t             sel,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [AW-1:0] ptr;
    logic          do_clear;
    logic          do_swap;
    logic          do_we;
    logic          take;
    logic          swap_ok;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign in_ready = !full && !clear && !swap_en && !we;

    // Mutually exclusive terms realise the clear > swap > write > load order.
    assign do_clear = clear;
    assign do_swap  = swap_en && !clear;
    assign do_we    = we && !clear && !swap_en;
    assign take     = in_valid && in_ready;

    assign swap_ok = (swap_a != swap_b)
                  && ({1'b0, swap_a} < DEPTH_C)
                  && ({1'b0, swap_b} < DEPTH_C);

    always_comb begin
        wen = '0;
        sel = SEL_STREAM;
        unique case (1'b1)
            do_clear: begin
                wen = '1;
                sel = SEL_ZERO;
            end
            do_swap: begin
                sel = SEL_SWAP;
                if (swap_ok) begin
                    wen[swap_a] = 1'b1;
                    wen[swap_b] = 1'b1;
                end
            end
            do_we: begin
                sel = SEL_WD;
                if ({1'b0, wa} < DEPTH_C) wen[wa] = 1'b1;
            end
            take: begin
                sel      = SEL_STREAM;
                wen[ptr] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ptr   <= '0;
        end else if (clear) begin
            count <= '0;
            ptr   <= '0;
        end else if (take) begin
            count <= count + 1'b1;
            if (ptr != LAST) ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sort_bank.sv
// Parametrised data bank for the sort datapath: stream load, random
// write, pairwise swap and clear, all entries exposed in parallel.
module sort_bank
    import sort_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic                   swap_en,
    input  logic [AW-1:0]          swap_a,
    input  logic [AW-1:0]          swap_b,
    output logic [DEPTH*WIDTH-1:0] data_flat,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [DEPTH-1:0] wen;
    sel_t             sel;

    sort_bank_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .in_valid(in_valid),
        .we      (we),
        .wa      (wa),
        .swap_en (swap_en),
        .swap_a  (swap_a),
        .swap_b  (swap_b),
        .in_ready(in_ready),
        .wen     (wen),
        .sel     (sel),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // A swapped entry takes its partner's pre-edge value.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = '0;
            unique case (sel)
                SEL_ZERO:   nxt[i] = '0;
                SEL_STREAM: nxt[i] = in_data;
                SEL_WD:     nxt[i] = wd;
                SEL_SWAP:   nxt[i] = (AW'(i) == swap_a) ? mem[swap_b]
                                                        : mem[swap_a];
                default:    nxt[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wen[i]) mem[i] <= nxt[i];
        end
    end

    always_comb begin
        data_flat = '0;
        for (int i = 0; i < DEPTH; i++)
            data_flat[i*WIDTH +: WIDTH] = mem[i];
    end

endmodule

// File: tb/tb_sort_bank.sv
// Directed bench for sort_bank with hand-computed expectations.
// Default geometry: 8 entries of 4 bits.
module tb_sort_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [2:0]  wa;
    logic [3:0]  wd;
    logic        swap_en;
    logic [2:0]  swap_a;
    logic [2:0]  swap_b;
    logic [31:0] data_flat;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    logic [3:0] vals [8];

    sort_bank dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .swap_en  (swap_en),
        .swap_a   (swap_a),
        .swap_b   (swap_b),
        .data_flat(data_flat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear    = 1'b0;
        in_valid = 1'b0;
        we       = 1'b0;
        swap_en  = 1'b0;
    endtask

    initial begin
        vals = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
        rst = 1'b1;
        idle();
        in_data = '0;
        wa = '0;
        wd = '0;
        swap_a = '0;
        swap_b = '0;

        #12;
        chk("rst_data", 64'(data_flat), 64'h0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = vals[k];
            #1;
            chk($sformatf("load_ready%0d", k), 64'(in_ready), 64'd1);
            step();
        end
        chk("load_ready_done", 64'(in_ready), 64'd0);
        chk("load_count", 64'(count), 64'd8);
        chk("load_full", 64'(full), 64'd1);
        chk("load_empty", 64'(empty), 64'd0);
        chk("load_data", 64'(data_flat), 64'h62951413);

        in_data = 4'd7;
        step();
        chk("drop_data", 64'(data_flat), 64'h62951413);
        chk("drop_count", 64'(count), 64'd8);

        idle();
        swap_en = 1'b1;
        swap_a = 3'd0;
        swap_b = 3'd5;
        step();
        chk("swap_0_5", 64'(data_flat), 64'h62351419);
        swap_a = 3'd2;
        swap_b = 3'd2;
        step();
        chk("swap_2_2", 64'(data_flat), 64'h62351419);
        swap_a = 3'd1;
        swap_b = 3'd7;
        step();
        chk("swap_1_7", 64'(data_flat), 64'h12351469);
        chk("swap_count", 64'(count), 64'd8);

        in_valid = 1'b1;
        in_data = 4'd8;
        we = 1'b1;
        wa = 3'd3;
        wd = 4'hF;
        swap_a = 3'd0;
        swap_b = 3'd1;
        #1;
        chk("prio_ready", 64'(in_ready), 64'd0);
        step();
        chk("prio_data", 64'(data_flat), 64'h12351496);
        chk("prio_count", 64'(count), 64'd8);

        idle();
        we = 1'b1;
        wa = 3'd4;
        wd = 4'hA;
        step();
        chk("write_4", 64'(data_flat), 64'h123A1496);
        chk("write_count", 64'(count), 64'd8);

        idle();
        clear = 1'b1;
        step();
        chk("clr_full_data", 64'(data_flat), 64'h0);
        chk("clr_full_count", 64'(count), 64'd0);

        idle();
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = 4'(k);
            step();
        end
        chk("five_data", 64'(data_flat), 64'h00054321);
        chk("five_count", 64'(count), 64'd5);

        idle();
        clear = 1'b1;
        we = 1'b1;
        wa = 3'd2;
        wd = 4'd7;
        step();
        chk("clr5_data", 64'(data_flat), 64'h0);
        chk("clr5_count", 64'(count), 64'd0);
        chk("clr5_empty", 64'(empty), 64'd1);

        idle();
        in_valid = 1'b1;
        in_data = 4'hC;
        step();
        chk("post_clr_data", 64'(data_flat), 64'h0000000C);
        chk("post_clr_count", 64'(count), 64'd1);

        in_data = 4'hD;
        step();
        in_data = 4'hE;
        step();
        chk("mid_count", 64'(count), 64'd3);
        chk("mid_data", 64'(data_flat), 64'h00000EDC);

        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", 64'(data_flat), 64'h0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        #3;
        rst = 1'b0;
        idle();
        step();
        chk("rel_count", 64'(count), 64'd0);
        chk("rel_ready", 64'(in_ready), 64'd1);
        chk("rel_data", 64'(data_flat), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
